apb_timer_gen: RTL and testbench

- Parametrised successor to the team's 8-bit APB timer: a WIDTH-bit up/down counter with a selectable power-of-two prescaler.
- Adds auto-reload, compare-match, a write-0-to-clear status register, interrupt enables and a level interrupt output.
- Sits on the APB bus as a zero-wait-state slave; drives irq to the interrupt controller.

---
 rtl/apb_timer_gen.sv | 163 ++++++++++++++++
 tb/tb_apb_timer_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer_gen.sv
// APB zero-wait-state WIDTH-bit up/down timer with power-of-two prescaler, auto-reload,
// write-0-to-clear status and a registered level irq. Define TIMER_CMP_EN to build the compare unit.
module apb_timer_gen #(
    parameter int WIDTH = 8,
    parameter int CKS_W = 2
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic             psel,
    input  logic             penable,
    input  logic             pwrite,
    input  logic [7:0]       paddr,
    input  logic [WIDTH-1:0] pwdata,
    output logic [WIDTH-1:0] prdata,
    output logic             pready,
    output logic             pslverr,
    output logic             irq
);
    localparam int PW = 2 ** CKS_W;
    localparam logic [7:0] A_TDR  = 8'h00;
    localparam logic [7:0] A_TCR  = 8'h01;
    localparam logic [7:0] A_TSR  = 8'h02;
    localparam logic [7:0] A_TCNT = 8'h03;
    localparam logic [7:0] A_TCMP = 8'h04;
    localparam logic [7:0] A_TIER = 8'h05;
`ifdef TIMER_CMP_EN
    localparam logic [2:0] FLAG_MASK = 3'b111;
`else
    localparam logic [2:0] FLAG_MASK = 3'b011;
`endif

    logic [WIDTH-1:0] tdr_q, tcnt_q, tcnt_d;
`ifdef TIMER_CMP_EN
    logic [WIDTH-1:0] tcmp_q;
`endif
    logic             load_q, down_q, en_q, arld_q;
    logic [CKS_W-1:0] cks_q;
    logic [2:0]       tsr_q, tsr_d, tier_q, hw_set, sw_clr;
    logic [PW-1:0]    pre_q, pre_d, pre_mask;
    logic             irq_q;
    logic             access, wr_en, tick, step;
    logic [7:0]       tcr_rd;

    assign access  = psel & penable;
    assign wr_en   = access & pwrite;
    assign pready  = 1'b1;
    assign pslverr = access && (paddr > A_TIER);
    assign irq     = irq_q;

    // Tick when the low (cks+1) prescaler bits are all ones; cks changes apply immediately.
    always_comb begin
        pre_mask = '0;
        for (int i = 0; i < PW; i++) begin
            pre_mask[i] = (i <= int'(cks_q));
        end
    end

    assign tick  = ((pre_q & pre_mask) == pre_mask);
    assign step  = en_q & tick & ~load_q;
    assign pre_d = (!en_q || load_q) ? '0 : pre_q + PW'(1);

    always_comb begin
        tcnt_d = tcnt_q;
        hw_set = '0;
        if (load_q) begin
            tcnt_d = tdr_q;
        end else if (step) begin
            if (!down_q) begin
                if (&tcnt_q) begin
                    tcnt_d    = arld_q ? tdr_q : '0;
                    hw_set[0] = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + WIDTH'(1);
                end
            end else begin
                if (tcnt_q == '0) begin
                    tcnt_d    = arld_q ? tdr_q : '1;
                    hw_set[1] = 1'b1;
                end else begin
                    tcnt_d = tcnt_q - WIDTH'(1);
                end
            end
`ifdef TIMER_CMP_EN
            if (tcnt_d == tcmp_q) hw_set[2] = 1'b1;
`endif
        end
    end

    // A hardware set in the same cycle as a software clear keeps the flag.
    always_comb begin
        sw_clr = '0;
        if (wr_en && (paddr == A_TSR)) sw_clr = ~pwdata[2:0];
        tsr_d = ((tsr_q & ~sw_clr) | hw_set) & FLAG_MASK;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tdr_q  <= '0;
            tcnt_q <= '0;
            load_q <= 1'b0;
            down_q <= 1'b0;
            en_q   <= 1'b0;
            arld_q <= 1'b0;
            cks_q  <= '0;
            tsr_q  <= '0;
            tier_q <= '0;
            pre_q  <= '0;
            irq_q  <= 1'b0;
`ifdef TIMER_CMP_EN
            tcmp_q <= '0;
`endif
        end else begin
            tcnt_q <= tcnt_d;
            tsr_q  <= tsr_d;
            pre_q  <= pre_d;
            irq_q  <= |(tsr_q & tier_q);
            if (wr_en) begin
                case (paddr)
                    A_TDR: tdr_q <= pwdata;
                    A_TCR: begin
                        load_q <= pwdata[7];
                        down_q <= pwdata[5];
                        en_q   <= pwdata[4];
                        arld_q <= pwdata[3];
                        cks_q  <= pwdata[CKS_W-1:0];
                    end
`ifdef TIMER_CMP_EN
                    A_TCMP: tcmp_q <= pwdata;
`endif
                    A_TIER: tier_q <= pwdata[2:0] & FLAG_MASK;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        tcr_rd            = '0;
        tcr_rd[CKS_W-1:0] = cks_q;
        tcr_rd[3]         = arld_q;
        tcr_rd[4]         = en_q;
        tcr_rd[5]         = down_q;
        tcr_rd[7]         = load_q;
    end

    always_comb begin
        prdata = '0;
        if (access && !pwrite) begin
            case (paddr)
                A_TDR:  prdata = tdr_q;
                A_TCR:  prdata = WIDTH'(tcr_rd);
                A_TSR:  prdata = WIDTH'(tsr_q);
                A_TCNT: prdata = tcnt_q;
`ifdef TIMER_CMP_EN
                A_TCMP: prdata = tcmp_q;
`endif
                A_TIER: prdata = WIDTH'(tier_q);
                default: prdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_timer_gen.sv
// Scoreboard bench for apb_timer_gen: an 8-bit/CKS_W=2 instance and a 16-bit/CKS_W=3 instance.
module tb_apb_timer_gen;
`ifdef TIMER_CMP_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif
    localparam logic [7:0] TDR = 8'h00, TCR = 8'h01, TSR = 8'h02;
    localparam logic [7:0] TCNT = 8'h03, TCMP = 8'h04, TIER = 8'h05;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        psel_a = 1'b0, psel_b = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0]  paddr = '0;
    logic [15:0] pwdata = '0;
    logic [7:0]  prdata_a;
    logic [15:0] prdata_b;
    logic        pready_a, pready_b, pslverr_a, pslverr_b, irq_a, irq_b;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned w;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    apb_timer_gen #(.WIDTH(8), .CKS_W(2)) ua (
        .pclk(pclk), .presetn(presetn), .psel(psel_a), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata[7:0]), .prdata(prdata_a),
        .pready(pready_a), .pslverr(pslverr_a), .irq(irq_a)
    );

    apb_timer_gen #(.WIDTH(16), .CKS_W(3)) ub (
        .pclk(pclk), .presetn(presetn), .psel(psel_b), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_b),
        .pready(pready_b), .pslverr(pslverr_b), .irq(irq_b)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int unsigned t);
        while (cyc < t) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic bus_idle();
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    // Returns one time unit after the edge at which the write lands.
    task automatic wr(input bit sel, input logic [7:0] addr, input logic [15:0] data);
        paddr  = addr;
        pwdata = data;
        pwrite = 1'b1;
        psel_a = !sel;
        psel_b = sel;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        @(posedge pclk);
        #1;
        bus_idle();
    endtask

    task automatic wr_at(input bit sel, input logic [7:0] addr, input logic [15:0] data,
                         input int unsigned t);
        wait_cyc(t - 2);
        wr(sel, addr, data);
    endtask

    // Samples the register state present after the next clock edge.
    task automatic rd(input bit sel, input logic [7:0] addr, input logic [31:0] exp,
                      input string tag);
        logic [31:0] obs;
        tag_q.push_back(tag);
        exp_q.push_back(exp);
        paddr  = addr;
        pwrite = 1'b0;
        psel_a = !sel;
        psel_b = sel;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        #2;
        obs = sel ? {16'h0, prdata_b} : {24'h0, prdata_a};
        check(tag_q.pop_front(), obs, exp_q.pop_front());
        check({tag, "_pslverr"}, 32'(sel ? pslverr_b : pslverr_a), 32'(addr > 8'h05));
        check({tag, "_pready"}, 32'(sel ? pready_b : pready_a), 32'h1);
        @(posedge pclk);
        #1;
        bus_idle();
    endtask

    task automatic rd_at(input bit sel, input logic [7:0] addr, input logic [31:0] exp,
                         input string tag, input int unsigned t);
        wait_cyc(t - 1);
        rd(sel, addr, exp, tag);
    endtask

    task automatic pulse_reset();
        presetn = 1'b0;
        #2;
        presetn = 1'b1;
        @(posedge pclk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge pclk);
        #1;
        check("rst_irq", 32'(irq_a), 32'h0);
        check("rst_pready", 32'(pready_a), 32'h1);
        check("rst_prdata_idle", 32'(prdata_a), 32'h0);
        check("rst_pslverr", 32'(pslverr_a), 32'h0);
        presetn = 1'b1;
        @(posedge pclk);
        #1;
        rd(0, TCNT, 32'h00, "rst_tcnt");
        rd(0, TSR, 32'h00, "rst_tsr");
        rd(0, TCR, 32'h00, "rst_tcr");
        rd(0, TDR, 32'h00, "rst_tdr");

        // up, en, div4 from zero: overflow exactly 1024 cycles after the write edge
        wr(0, TCR, 16'h11);
        w = cyc;
        rd_at(0, TSR, 32'h00, "up4_tsr_1000", w + 1000);
        rd_at(0, TSR, 32'h00, "up4_tsr_1023", w + 1023);
        rd_at(0, TSR, 32'h01, "up4_tsr_1024", w + 1024);
        rd(0, TCR, 32'h11, "up4_tcr");
        wr(0, TSR, 16'h00);
        rd(0, TSR, 32'h00, "up4_tsr_clr");
        check("up4_irq", 32'(irq_a), 32'h0);
        pulse_reset();

        // load then count down by 2
        wr(0, TDR, 16'h05);
        wr(0, TCR, 16'h80);
        rd(0, TCNT, 32'h05, "dn_load");
        wr(0, TCR, 16'h30);
        w = cyc;
        rd_at(0, TSR, 32'h00, "dn_tsr_11", w + 11);
        rd_at(0, TCNT, 32'hFF, "dn_tcnt_wrap", w + 13);
        rd_at(0, TSR, 32'h02, "dn_udf", w + 15);
        pulse_reset();

        // auto-reload from 0xF0, up by 2
        wr(0, TDR, 16'hF0);
        wr(0, TCR, 16'h80);
        wr(0, TCR, 16'h1C);
        w = cyc;
        rd_at(0, TSR, 32'h00, "arld_tsr_31", w + 31);
        rd_at(0, TCNT, 32'hF0, "arld_reload1", w + 33);
        wr(0, TSR, 16'h00);
        rd_at(0, TSR, 32'h00, "arld_tsr_62", w + 62);
        rd_at(0, TCNT, 32'hF0, "arld_reload2", w + 64);
        rd_at(0, TSR, 32'h01, "arld_ovf2", w + 66);
        rd(0, TCR, 32'h18, "arld_tcr_mask");
        pulse_reset();

        // compare match with interrupt enable
        wr(0, TCMP, 16'h10);
        wr(0, TIER, 16'h04);
        wr(0, TCR, 16'h10);
        w = cyc;
        rd_at(0, TSR, 32'h00, "cmp_tsr_31", w + 31);
        check("cmp_irq_32", 32'(irq_a), 32'h0);
        rd_at(0, TSR, CMP ? 32'h04 : 32'h00, "cmp_tsr_33", w + 33);
        check("cmp_irq_34", 32'(irq_a), CMP ? 32'h1 : 32'h0);
        wr(0, TSR, 16'h03);
        check("cmp_irq_clr_edge", 32'(irq_a), CMP ? 32'h1 : 32'h0);
        wait_cyc(w + 37);
        check("cmp_irq_fall", 32'(irq_a), 32'h0);
        rd(0, TSR, 32'h00, "cmp_tsr_clr");
        rd(0, TCMP, CMP ? 32'h10 : 32'h00, "cmp_tcmp");
        rd(0, TIER, CMP ? 32'h04 : 32'h00, "cmp_tier");
        pulse_reset();

        // unmapped addresses and read-only counter
        rd(0, 8'h07, 32'h00, "err_07");
        rd(0, 8'h06, 32'h00, "err_06");
        wr(0, TCNT, 16'h55);
        rd(0, TCNT, 32'h00, "tcnt_ro");

        // asynchronous reset in the middle of counting with a pending interrupt
        wr(0, TIER, 16'h01);
        wr(0, TDR, 16'hFE);
        wr(0, TCR, 16'h80);
        wr(0, TCR, 16'h11);
        w = cyc;
        rd_at(0, TSR, 32'h01, "mid_ovf", w + 10);
        rd_at(0, TCNT, 32'h01, "mid_tcnt", w + 13);
        check("mid_irq", 32'(irq_a), 32'h1);
        presetn = 1'b0;
        #1;
        check("mid_irq_async", 32'(irq_a), 32'h0);
        #1;
        presetn = 1'b1;
        @(posedge pclk);
        #1;
        rd(0, TCNT, 32'h00, "mid_tcnt_rst");
        rd(0, TSR, 32'h00, "mid_tsr_rst");
        rd(0, TIER, 32'h00, "mid_tier_rst");

        // 16-bit instance: overflow with a same-cycle software clear
        wr(1, TDR, 16'hFF00);
        wr(1, TCR, 16'h80);
        wr(1, TCR, 16'h10);
        w = cyc;
        rd_at(1, TSR, 32'h00, "w16_tsr_508", w + 508);
        wr_at(1, TSR, 16'h0000, w + 512);
        rd_at(1, TSR, 32'h01, "w16_set_wins", w + 514);
        rd_at(1, TCNT, 32'h0002, "w16_tcnt", w + 516);
        check("w16_irq", 32'(irq_b), 32'h0);
        wr(1, TSR, 16'h0000);
        rd(1, TSR, 32'h00, "w16_tsr_clr");
        wr(1, TCR, 16'h2F);
        rd(1, TCR, 32'h2F, "w16_tcr");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
